// File: rtl/alu_request_arbiter.sv
// Two-requester front end for one shared ALU: arbitrates, issues one operation, holds the result until taken.
// Optional macro ALU_ARB_ROUND_ROBIN_EN: alternate winners under contention (default: requester 0 wins).
module alu_request_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [3:0]  req_op_0,
   input  logic [31:0] req_a_0,
   input  logic [31:0] req_b_0,
   input  logic [3:0]  req_op_1,
   input  logic [31:0] req_a_1,
   input  logic [31:0] req_b_1,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_sign,
   output logic [3:0]  alu_operation,
   output logic [31:0] alu_operand_1,
   output logic [31:0] alu_operand_2,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   input  logic        alu_sign,
   output logic [1:0]  state_dbg
);

   // Handshake: a request moves on a rising edge where req_valid[n] & req_ready[n];
   // a response moves on a rising edge where rsp_valid & rsp_ready.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   grant;
   logic   last_grant;
   logic   win;
   logic   accept;

`ifdef ALU_ARB_ROUND_ROBIN_EN
   always_comb begin
      win = (req_valid == 2'b11) ? ~last_grant : (req_valid == 2'b10);
   end
`else
   always_comb begin
      win = (req_valid == 2'b10);
   end
`endif

   always_comb begin
      state_nxt = state;
      req_ready = 2'b00;
      case (state)
         IDLE: begin
            if (req_valid != 2'b00) begin
               req_ready = win ? 2'b10 : 2'b01;
               state_nxt = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept    = (state == IDLE) && (req_valid != 2'b00);
   assign rsp_valid = (state == RESP);
   assign state_dbg = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Operands stay on the ALU inputs until the next acceptance, not just through EXEC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_operation <= 4'd0;
         alu_operand_1 <= 32'd0;
         alu_operand_2 <= 32'd0;
         grant         <= 1'b0;
         last_grant    <= 1'b1;
      end else if (accept) begin
         alu_operation <= win ? req_op_1 : req_op_0;
         alu_operand_1 <= win ? req_a_1  : req_a_0;
         alu_operand_2 <= win ? req_b_1  : req_b_0;
         grant         <= win;
         last_grant    <= win;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_id     <= 1'b0;
         rsp_result <= 32'd0;
         rsp_zero   <= 1'b0;
         rsp_sign   <= 1'b0;
      end else if (state == EXEC) begin
         rsp_id     <= grant;
         rsp_result <= alu_result;
         rsp_zero   <= alu_zero;
         rsp_sign   <= alu_sign;
      end
   end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Scoreboard bench for alu_request_arbiter: models the shared ALU and predicts grants/results per transaction.
module tb_alu_request_arbiter;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;
   localparam logic [3:0] ALU_SRA = 4'd7;
   localparam int W = 67;  // {id, result, zero, sign, accept_cycle}
`ifdef ALU_ARB_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_op_0, req_op_1;
   logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_sign;
   logic [31:0] rsp_result;
   logic [3:0]  alu_operation;
   logic [31:0] alu_operand_1, alu_operand_2, alu_result;
   logic        alu_zero, alu_sign;
   logic [1:0]  state_dbg;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by the test
   logic        model_last = 1'b1;
   logic [W-1:0] exp_q[$];
   logic        id_log[$];
   logic [W-1:0] cur;
   logic        prev_valid = 1'b0;
   logic        last_id;
   logic [31:0] last_result;
   logic        last_zero, last_sign;

   alu_request_arbiter dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op_0(req_op_0), .req_a_0(req_a_0), .req_b_0(req_b_0),
      .req_op_1(req_op_1), .req_a_1(req_a_1), .req_b_1(req_b_1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign),
      .alu_operation(alu_operation), .alu_operand_1(alu_operand_1),
      .alu_operand_2(alu_operand_2), .alu_result(alu_result),
      .alu_zero(alu_zero), .alu_sign(alu_sign), .state_dbg(state_dbg)
   );

   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         ALU_SLL: return a << b[4:0];
         ALU_SRL: return a >> b[4:0];
         ALU_SRA: return $unsigned($signed(a) >>> b[4:0]);
         default: return 32'd0;
      endcase
   endfunction

   // Shared ALU seen by the arbiter.
   assign alu_result = alu_fn(alu_operation, alu_operand_1, alu_operand_2);
   assign alu_zero   = (alu_result == 32'd0);
   assign alu_sign   = alu_result[31];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   initial begin
      rsp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) rsp_ready = 1'b1;
         else if (rdy_mode == 1) rsp_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: pops one expectation per response and checks it stays put while held.
   always @(negedge clk) begin
      if (!reset) begin
         chk("req_ready_not_both", {31'd0, req_ready == 2'b11}, 32'd0);
         if (rsp_valid) begin
            if (!prev_valid) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_rsp: response id %0d result 0x%08h with none pending", rsp_id, rsp_result);
                  cur = {rsp_id, rsp_result, rsp_zero, rsp_sign, 32'(cyc - 2)};
               end else begin
                  cur = exp_q.pop_front();
                  chk("rsp_latency", 32'(cyc), cur[31:0] + 32'd2);
               end
               last_id     = rsp_id;
               last_result = rsp_result;
               last_zero   = rsp_zero;
               last_sign   = rsp_sign;
               id_log.push_back(rsp_id);
            end
            chk("rsp_id", {31'd0, rsp_id}, {31'd0, cur[66]});
            chk("rsp_result", rsp_result, cur[65:34]);
            chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, cur[33]});
            chk("rsp_sign", {31'd0, rsp_sign}, {31'd0, cur[32]});
            chk("req_ready_busy", {30'd0, req_ready}, 32'd0);
         end
      end
      prev_valid = rsp_valid;
   end

   // Holds the request until the DUT takes it; the expected winner comes from the arbitration rule.
   task automatic issue(input logic [1:0] mask,
                        input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1);
      bit          got = 1'b0;
      logic        w;
      logic [31:0] r;
      req_valid = mask;
      req_op_0 = op0; req_a_0 = a0; req_b_0 = b0;
      req_op_1 = op1; req_a_1 = a1; req_b_1 = b1;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            got = 1'b1;
            if (mask == 2'b11) w = RR_EN ? ~model_last : 1'b0;
            else               w = mask[1];
            chk("grant_onehot", {30'd0, req_ready}, w ? 32'd2 : 32'd1);
            r = w ? alu_fn(op1, a1, b1) : alu_fn(op0, a0, b0);
            exp_q.push_back({w, r, r == 32'd0, r[31], 32'(cyc)});
            model_last = w;
         end
         @(posedge clk);
         #1;
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL issue_timeout: mask %b never accepted", mask);
      end
      req_valid = 2'b00;
   endtask

   task automatic wait_done();
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !rsp_valid) done = 1'b1;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic exp_ids [4];
      logic [1:0] m;
      logic [3:0] o0, o1;
      bit seen;

      reset = 1'b1;
      req_valid = 2'b00;
      req_op_0 = 4'd0; req_a_0 = 32'd0; req_b_0 = 32'd0;
      req_op_1 = 4'd0; req_a_1 = 32'd0; req_b_1 = 32'd0;
      #12;
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset_alu_operation", {28'd0, alu_operation}, 32'd0);
      chk("reset_rsp_result", rsp_result, 32'd0);
      req_valid = 2'b11;
      #1;
      chk("reset_req_ready_comb", {30'd0, req_ready}, 32'd1);
      req_valid = 2'b00;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;

      // Continuous contention from reset.
      id_log.delete();
      for (int i = 0; i < 4; i++)
         issue(2'b11, ALU_ADD, 32'(i), 32'd1, ALU_SUB, 32'(i), 32'd1);
      wait_done();
      for (int i = 0; i < 4; i++) exp_ids[i] = RR_EN ? 1'(i % 2) : 1'b0;
      chk("contention_count", 32'(id_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < id_log.size(); i++)
         chk("contention_id_seq", {31'd0, id_log[i]}, {31'd0, exp_ids[i]});

      issue(2'b01, ALU_ADD, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0);
      wait_done();
      chk("add_result", last_result, 32'd12);
      chk("add_zero", {31'd0, last_zero}, 32'd0);
      chk("add_sign", {31'd0, last_sign}, 32'd0);
      chk("add_id", {31'd0, last_id}, 32'd0);

      issue(2'b10, ALU_ADD, 32'd0, 32'd0, ALU_SUB, 32'd3, 32'd3);
      wait_done();
      chk("sub_result", last_result, 32'd0);
      chk("sub_zero", {31'd0, last_zero}, 32'd1);
      chk("sub_sign", {31'd0, last_sign}, 32'd0);
      chk("sub_id", {31'd0, last_id}, 32'd1);

      // Held response with a requester that gives up before it is served.
      rdy_mode = 2;
      #2;
      rsp_ready = 1'b0;
      issue(2'b01, ALU_SRA, 32'h8000_0000, 32'd4, ALU_ADD, 32'd0, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = rsp_valid;
      end
      chk("sra_rsp_seen", {31'd0, seen}, 32'd1);
      req_valid = 2'b10;
      req_op_1 = ALU_ADD; req_a_1 = 32'd9; req_b_1 = 32'd9;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("sra_hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("sra_hold_result", rsp_result, 32'hF800_0000);
         chk("sra_hold_sign", {31'd0, rsp_sign}, 32'd1);
         chk("sra_hold_req_ready", {30'd0, req_ready}, 32'd0);
      end
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("sra_idle_after_ready", {31'd0, rsp_valid}, 32'd0);
      req_valid = 2'b01;
      #1;
      chk("sra_idle_req_ready", {30'd0, req_ready}, 32'd1);
      req_valid = 2'b00;
      repeat (3) @(negedge clk);
      chk("dropped_req_no_txn", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
      rdy_mode = 0;

      // Reset in EXEC abandons the transaction.
      issue(2'b01, ALU_ADD, 32'd1, 32'd2, ALU_ADD, 32'd0, 32'd0);
      #1;
      reset = 1'b1;
      exp_q.delete();
      model_last = 1'b1;
      #1;
      chk("rst_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_exec_rsp_result", rsp_result, 32'd0);
      chk("rst_exec_rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("rst_exec_rsp_flags", {30'd0, rsp_zero, rsp_sign}, 32'd0);
      chk("rst_exec_alu_operation", {28'd0, alu_operation}, 32'd0);
      chk("rst_exec_alu_operand_1", alu_operand_1, 32'd0);
      chk("rst_exec_alu_operand_2", alu_operand_2, 32'd0);
      chk("rst_exec_req_ready", {30'd0, req_ready}, 32'd0);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      issue(2'b10, ALU_ADD, 32'd0, 32'd0, ALU_XOR, 32'h0000_00FF, 32'h0000_000F);
      wait_done();
      chk("xor_result", last_result, 32'h0000_00F0);
      chk("xor_id", {31'd0, last_id}, 32'd1);

      // Random traffic with random response back-pressure.
      rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
         m  = 2'($urandom_range(1, 3));
         o0 = 4'($urandom_range(0, 7));
         o1 = 4'($urandom_range(0, 7));
         issue(m, o0, $urandom, $urandom, o1, $urandom, $urandom);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      wait_done();
      rdy_mode = 0;
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
